regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x64 integer register file between two writeback requesters: req0 (ALU) and req1 (load unit).
- Round-robin arbitration with valid/ready handshakes per requester.
- Registered drive of the register file's RegWrite/rd/WriteData inputs.
- A pending-write scoreboard flags read-after-write hazards on rs1/rs2 so issue logic can stall.

---
 rtl/regfile_write_arbiter_if.sv | 55 +++++
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 tb/tb_regfile_write_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bundle: two requester channels, issue/read ports, and the register-file write port.
// Latency: none (wires only); the arbiter modport owns all timing.
// Backpressure: req0_ready/req1_ready flow from the arbiter back to the requesters.
//
// Ports (arbiter view, modport slave):
//   in : req0_valid/rd/data, req1_valid/rd/data, issue_valid/issue_rd, rs1, rs2
//   out: req0_ready, req1_ready, hazard1, hazard2, RegWrite, rd, WriteData, err_unexpected
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              hazard1;
    logic              hazard2;

    logic              RegWrite;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] WriteData;
    logic              err_unexpected;

    // Requester / issue side.
    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        output issue_valid, issue_rd, rs1, rs2,
        input  hazard1, hazard2,
        input  RegWrite, rd, WriteData, err_unexpected
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        input  issue_valid, issue_rd, rs1, rs2,
        output hazard1, hazard2,
        output RegWrite, rd, WriteData, err_unexpected
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (req0) and load (req1), with a pending-write scoreboard.
// Latency: an acceptance in cycle N drives RegWrite/rd/WriteData in cycle N+1; hazards are combinational.
// Backpressure: at most one requester gets ready per cycle; the loser holds valid and is favoured next time.
//
// Ports: clk, reset (async, active-low), bus (regfile_write_arbiter_if.slave).
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    logic                prio;          // 0: req0 favoured, 1: req1 favoured
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    logic                reg_write_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   write_data_q;
    logic                err_q;

    logic                grant0;
    logic                grant1;
    logic                accept;
    logic [ADDR_W-1:0]   acc_rd;
    logic [DATA_W-1:0]   acc_data;
    logic                acc_real;      // accepted and targets a real (non-x0) register

    // Readies are held low while reset is asserted so nothing is consumed and lost.
    assign grant0 = reset & bus.req0_valid & (~bus.req1_valid | ~prio);
    assign grant1 = reset & bus.req1_valid & (~bus.req0_valid |  prio);
    assign accept = grant0 | grant1;

    assign acc_rd   = grant0 ? bus.req0_rd   : bus.req1_rd;
    assign acc_data = grant0 ? bus.req0_data : bus.req1_data;
    assign acc_real = accept & (acc_rd != '0);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Clear first, then set: a same-index issue represents a newer producer and must win.
    always_comb begin
        pending_nxt = pending;
        if (acc_real) begin
            pending_nxt[acc_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            pending_nxt[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio         <= 1'b0;
            pending      <= '0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            pending     <= pending_nxt;
            reg_write_q <= acc_real;

            // rd/WriteData only move on a real write; otherwise they hold.
            if (acc_real) begin
                rd_q         <= acc_rd;
                write_data_q <= acc_data;
            end

            // Point at the requester that just lost (or did not ask).
            if (grant0) begin
                prio <= 1'b1;
            end else if (grant1) begin
                prio <= 1'b0;
            end

            if (acc_real && !pending[acc_rd]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.hazard1        = (bus.rs1 != '0) & pending[bus.rs1];
    assign bus.hazard2        = (bus.rs2 != '0) & pending[bus.rs2];
    assign bus.RegWrite       = reg_write_q;
    assign bus.rd             = rd_q;
    assign bus.WriteData      = write_data_q;
    assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, write path, round-robin, scoreboard, x0 and error cases.
// Latency: inputs driven 1 time unit after posedge; registered outputs checked 1 unit after the following posedge.
// Backpressure: requesters hold valid/rd/data until the expected grant cycle.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic clk;
    logic reset;

    int vec_cnt;
    int miscmp_cnt;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid  = 1'b0;
        bus.req0_rd     = '0;
        bus.req0_data   = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_rd     = '0;
        bus.req1_data   = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        reset      = 1'b0;
        idle_inputs();
        bus.rs1 = '0;
        bus.rs2 = '0;

        // In reset: ready forced low even with a valid request.
        #2;
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd3;
        #1;
        check("rst_ready0_forced", {63'd0, bus.req0_ready}, 64'd0);
        check("rst_regwrite", {63'd0, bus.RegWrite}, 64'd0);
        check("rst_wdata", bus.WriteData, 64'd0);
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        check("idle_regwrite", {63'd0, bus.RegWrite}, 64'd0);
        check("idle_hazard1", {63'd0, bus.hazard1}, 64'd0);
        check("idle_hazard2", {63'd0, bus.hazard2}, 64'd0);
        check("idle_err", {63'd0, bus.err_unexpected}, 64'd0);
        check("idle_ready0", {63'd0, bus.req0_ready}, 64'd0);
        check("idle_ready1", {63'd0, bus.req1_ready}, 64'd0);

        // Issue rd=5, then ALU writes rd=5.
        cyc();
        bus.rs1         = 5'd5;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        cyc();
        bus.issue_valid = 1'b0;
        #1;
        check("raw5_hazard_set", {63'd0, bus.hazard1}, 64'd1);
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd5;
        bus.req0_data  = 64'hDEAD;
        #1;
        check("raw5_ready0", {63'd0, bus.req0_ready}, 64'd1);
        check("raw5_hazard_hold", {63'd0, bus.hazard1}, 64'd1);
        cyc();
        idle_inputs();
        #1;
        check("raw5_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        check("raw5_rd", {59'd0, bus.rd}, 64'd5);
        check("raw5_wdata", bus.WriteData, 64'hDEAD);
        check("raw5_hazard_clr", {63'd0, bus.hazard1}, 64'd0);
        cyc();
        check("raw5_pulse_end", {63'd0, bus.RegWrite}, 64'd0);
        check("raw5_rd_hold", {59'd0, bus.rd}, 64'd5);

        // Set and clear of rd=9 in the same cycle: set wins. Leaves prio favouring req0.
        bus.rs2         = 5'd9;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        cyc();
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd9;
        bus.req1_data  = 64'h99;
        #1;
        check("sb9_ready1", {63'd0, bus.req1_ready}, 64'd1);
        check("sb9_hazard_pre", {63'd0, bus.hazard2}, 64'd1);
        cyc();
        idle_inputs();
        #1;
        check("sb9_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        check("sb9_rd", {59'd0, bus.rd}, 64'd9);
        check("sb9_hazard_kept", {63'd0, bus.hazard2}, 64'd1);
        check("sb9_err", {63'd0, bus.err_unexpected}, 64'd0);
        cyc();
        check("sb9_hazard_later", {63'd0, bus.hazard2}, 64'd1);

        // Round-robin: both valid for 4 cycles; re-issue the granted rd each cycle so the next write is still expected.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        cyc();
        bus.issue_rd    = 5'd7;
        cyc();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd6;
        bus.req0_data  = 64'h6666;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd7;
        bus.req1_data  = 64'h7777;
        for (int i = 0; i < 4; i++) begin
            bus.issue_rd = (i % 2 == 0) ? 5'd6 : 5'd7;
            #1;
            check($sformatf("rr%0d_ready0", i), {63'd0, bus.req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("rr%0d_ready1", i), {63'd0, bus.req1_ready}, (i % 2 == 0) ? 64'd0 : 64'd1);
            cyc();
            check($sformatf("rr%0d_regwrite", i), {63'd0, bus.RegWrite}, 64'd1);
            check($sformatf("rr%0d_rd", i), {59'd0, bus.rd}, (i % 2 == 0) ? 64'd6 : 64'd7);
            check($sformatf("rr%0d_wdata", i), bus.WriteData, (i % 2 == 0) ? 64'h6666 : 64'h7777);
        end
        idle_inputs();
        cyc();
        check("rr_pulse_end", {63'd0, bus.RegWrite}, 64'd0);
        check("rr_err", {63'd0, bus.err_unexpected}, 64'd0);

        // rd=0 write is consumed but never writes; x0 is never hazarded.
        bus.rs1         = 5'd0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.req0_valid  = 1'b1;
        bus.req0_rd     = 5'd0;
        bus.req0_data   = 64'hFFFF;
        #1;
        check("x0_ready0", {63'd0, bus.req0_ready}, 64'd1);
        cyc();
        idle_inputs();
        #1;
        check("x0_regwrite", {63'd0, bus.RegWrite}, 64'd0);
        check("x0_hazard1", {63'd0, bus.hazard1}, 64'd0);
        check("x0_err", {63'd0, bus.err_unexpected}, 64'd0);

        // Unexpected write to rd=12: write proceeds, error is sticky.
        cyc();
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd12;
        bus.req1_data  = 64'h1212;
        #1;
        check("err12_ready1", {63'd0, bus.req1_ready}, 64'd1);
        cyc();
        idle_inputs();
        #1;
        check("err12_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        check("err12_rd", {59'd0, bus.rd}, 64'd12);
        check("err12_wdata", bus.WriteData, 64'h1212);
        check("err12_err_set", {63'd0, bus.err_unexpected}, 64'd1);
        cyc();
        cyc();
        check("err12_err_sticky", {63'd0, bus.err_unexpected}, 64'd1);

        // Mid-stream reset: accept in cycle N, reset before N+1 edge drops the write.
        bus.rs1         = 5'd20;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd20;
        cyc();
        bus.issue_valid = 1'b0;
        #1;
        check("mid_hazard_pre", {63'd0, bus.hazard1}, 64'd1);
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd20;
        bus.req0_data  = 64'hABC;
        #1;
        check("mid_ready0_pre", {63'd0, bus.req0_ready}, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_ready0_rst", {63'd0, bus.req0_ready}, 64'd0);
        check("mid_hazard_rst", {63'd0, bus.hazard1}, 64'd0);
        check("mid_hazard2_rst", {63'd0, bus.hazard2}, 64'd0);
        check("mid_err_rst", {63'd0, bus.err_unexpected}, 64'd0);
        cyc();
        check("mid_regwrite_dropped", {63'd0, bus.RegWrite}, 64'd0);
        check("mid_rd_rst", {59'd0, bus.rd}, 64'd0);
        idle_inputs();
        reset = 1'b1;
        cyc();
        check("mid_after_regwrite", {63'd0, bus.RegWrite}, 64'd0);
        check("mid_after_hazard", {63'd0, bus.hazard1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
